// File: rtl/miner_multicore_ctrl.sv
// miner_multicore_ctrl: round/nonce sequencer and golden-nonce collector for NUM_CORES hash cores.
// Latency: hit sampled on edge N -> pending on edge N -> FIFO write on edge N+1 -> gn_valid after N+1.
// Backpressure: gn_ready low lets the golden FIFO fill, and overflow entries bump drop_count.
// Ports: hash_clk/reset_n clock and async reset; new_work restarts the nonce space.
//   Core side: cnt, feedback and core_nonce go to the cores; hash_top comes back from them.
//   Host side: gn_valid/gn_ready/gn_data handshake, plus fifo_level, drop_count and exhausted status.

// Small first-word-fall-through FIFO with synchronous flush; out_dat reads 0 when empty.
module miner_gn_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int W          = 32
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [W-1:0]          in_dat,
  output logic                  in_drop,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [W-1:0]          out_dat,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    full;
  logic                    do_pop;
  logic                    do_push;

  assign full    = (level == FULL_LVL);
  assign out_vld = (level != '0);
  assign do_pop  = out_vld && out_rdy && !flush;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = in_vld && (!full || do_pop) && !flush;
  assign in_drop = in_vld && !do_push && !flush;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge hash_clk) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
        2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module miner_multicore_ctrl #(
  parameter int          NUM_CORES       = 4,
  parameter int          LOOP_LOG2       = 5,
  parameter logic [31:0] NONCE_START     = 32'd0,
  parameter int          DIFF_BITS       = 32,
  parameter int          GOLDEN_OFFSET   = (1 << (7 - LOOP_LOG2)) + 1,
  parameter int          FIFO_DEPTH_LOG2 = 3
) (
  input  logic                        hash_clk,
  input  logic                        reset_n,
  input  logic                        new_work,
  output logic [5:0]                  cnt,
  output logic                        feedback,
  output logic [NUM_CORES*32-1:0]     core_nonce,
  input  logic [NUM_CORES*32-1:0]     hash_top,
  output logic                        gn_valid,
  input  logic                        gn_ready,
  output logic [31:0]                 gn_data,
  output logic [FIFO_DEPTH_LOG2:0]    fifo_level,
  output logic [7:0]                  drop_count,
  output logic                        exhausted
);
  localparam logic [5:0]  CNT_MASK   = 6'((1 << LOOP_LOG2) - 1);
  localparam logic [31:0] CORES_W    = 32'(NUM_CORES);
  // Results surface GOLDEN_OFFSET rounds after issue, so the tag looks back that many bases.
  localparam logic [31:0] TAG_OFS    = 32'(GOLDEN_OFFSET * NUM_CORES);
  localparam logic [7:0]  FLUSH_INIT = 8'(GOLDEN_OFFSET);

  logic [31:0]          base;
  logic [31:0]          tag;
  logic [32:0]          base_sum;
  logic                 issue;
  logic                 sample;
  logic [7:0]           flush_cnt;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] pending;
  logic [4:0]           hit_count;
  logic                 sample_hit;
  logic                 sample_drop;
  logic                 drain_vld;
  logic [4:0]           drain_idx;
  logic [31:0]          drain_dat;
  logic                 fifo_drop;
  logic [9:0]           drop_sum;

  always_comb begin
    issue     = (cnt == 6'd0);
    feedback  = !issue;
    base_sum  = {1'b0, base} + {1'b0, CORES_W};
    core_nonce = '0;
    hit        = '0;
    hit_count  = '0;
    drain_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_nonce[32*i +: 32] = base + 32'(i);
      hit[i]    = (hash_top[32*i+31 -: DIFF_BITS] == '0);
      hit_count = hit_count + {4'd0, hit[i]};
    end
    // Scan downward so the lowest set bit wins.
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (pending[i]) drain_idx = 5'(i);
    end
    drain_vld   = (pending != '0);
    drain_dat   = tag + {27'd0, drain_idx};
    // Results still inside the post-restart window belong to stale work.
    sample_hit  = sample && (flush_cnt == 8'd0) && (hit != '0);
    sample_drop = sample_hit && drain_vld;
    drop_sum    = {2'b0, drop_count} + {5'd0, sample_drop ? hit_count : 5'd0} + {9'd0, fifo_drop};
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      base       <= NONCE_START;
      tag        <= '0;
      sample     <= 1'b0;
      flush_cnt  <= FLUSH_INIT;
      pending    <= '0;
      drop_count <= '0;
      exhausted  <= 1'b0;
    end else if (new_work) begin
      cnt       <= '0;
      base      <= NONCE_START;
      sample    <= 1'b0;
      flush_cnt <= FLUSH_INIT;
      pending   <= '0;
      exhausted <= 1'b0;
    end else begin
      cnt    <= (cnt + 6'd1) & CNT_MASK;
      sample <= issue;
      if (issue) begin
        base <= base_sum[31:0];
        if (base_sum[32]) exhausted <= 1'b1;
      end
      if (sample && flush_cnt != 8'd0) flush_cnt <= flush_cnt - 8'd1;
      if (sample_hit && !sample_drop) begin
        pending <= hit;
        tag     <= base - TAG_OFS;
      end else begin
        pending <= pending & (pending - NUM_CORES'(1));
      end
      drop_count <= (drop_sum > 10'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

  miner_gn_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .W          (32)
  ) u_gn_fifo (
    .hash_clk (hash_clk),
    .reset_n  (reset_n),
    .flush    (new_work),
    .in_vld   (drain_vld),
    .in_dat   (drain_dat),
    .in_drop  (fifo_drop),
    .out_vld  (gn_valid),
    .out_rdy  (gn_ready),
    .out_dat  (gn_data),
    .level    (fifo_level)
  );
endmodule

// File: tb/tb_miner_multicore_ctrl.sv
// tb_miner_multicore_ctrl: directed scenarios with a golden-nonce scoreboard.
// Latency: n/a (bench).
// Backpressure: gn_ready is toggled by the stimulus to fill and drain the FIFO.
module tb_miner_multicore_ctrl;
  logic          hash_clk = 1'b0;
  logic          reset_n;
  logic          new_work;
  logic          new_work_ex;
  logic [5:0]    cnt, cnt_ex;
  logic          feedback, feedback_ex;
  logic [127:0]  core_nonce, core_nonce_ex;
  logic [127:0]  hash_top, hash_top_ex;
  logic          gn_valid, gn_valid_ex;
  logic          gn_ready, gn_ready_ex;
  logic [31:0]   gn_data, gn_data_ex;
  logic [3:0]    fifo_level, fifo_level_ex;
  logic [7:0]    drop_count, drop_count_ex;
  logic          exhausted, exhausted_ex;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            work_cyc0 = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   exp_data;

  always #5 hash_clk = ~hash_clk;

  miner_multicore_ctrl #(
    .NUM_CORES(4), .LOOP_LOG2(5), .NONCE_START(32'd0), .DIFF_BITS(32),
    .GOLDEN_OFFSET(5), .FIFO_DEPTH_LOG2(3)
  ) dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .new_work(new_work), .cnt(cnt),
    .feedback(feedback), .core_nonce(core_nonce), .hash_top(hash_top),
    .gn_valid(gn_valid), .gn_ready(gn_ready), .gn_data(gn_data),
    .fifo_level(fifo_level), .drop_count(drop_count), .exhausted(exhausted)
  );

  miner_multicore_ctrl #(
    .NUM_CORES(4), .LOOP_LOG2(5), .NONCE_START(32'hFFFF_FFF8), .DIFF_BITS(32),
    .GOLDEN_OFFSET(5), .FIFO_DEPTH_LOG2(3)
  ) dut_ex (
    .hash_clk(hash_clk), .reset_n(reset_n), .new_work(new_work_ex), .cnt(cnt_ex),
    .feedback(feedback_ex), .core_nonce(core_nonce_ex), .hash_top(hash_top_ex),
    .gn_valid(gn_valid_ex), .gn_ready(gn_ready_ex), .gn_data(gn_data_ex),
    .fifo_level(fifo_level_ex), .drop_count(drop_count_ex), .exhausted(exhausted_ex)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] nonce_vec(input logic [31:0] b);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = b + 32'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge hash_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Drive zero hash_top on the masked cores in sample cycle k of the current work;
  // returns just after the sampling edge. Expected tag = 4k - 20.
  task automatic hit_at(input int k, input logic [3:0] mask, input bit expect_q);
    run_to(work_cyc0 + 32*(k-1) + 1);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        hash_top[32*i +: 32] = 32'd0;
        if (expect_q) exp_q.push_back(32'(4*k - 20 + i));
      end
    end
    tick();
    hash_top = '1;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    tick();
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard monitor: a pop happens at the next edge when valid && ready (and no restart).
  always @(negedge hash_clk) begin
    if (reset_n && gn_valid && gn_ready && !new_work) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gn_unexpected: got %0h expected nothing", gn_data);
      end else begin
        exp_data = exp_q.pop_front();
        check("gn_pop", {96'd0, gn_data}, {96'd0, exp_data});
      end
    end
  end

  initial begin
    reset_n = 1'b0; new_work = 1'b0; new_work_ex = 1'b0;
    gn_ready = 1'b0; gn_ready_ex = 1'b0;
    hash_top = '1; hash_top_ex = '1;
    repeat (3) @(posedge hash_clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;

    // Reset state
    check("rst_cnt", cnt, 0);
    check("rst_feedback", feedback, 0);
    check("rst_gn_valid", gn_valid, 0);
    check("rst_gn_data", gn_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_nonce", core_nonce, nonce_vec(32'd0));
    check("rst_ex_nonce", core_nonce_ex[31:0], 32'hFFFF_FFF8);

    // Round counter / nonce issue; exhaustion on the second issue of dut_ex
    for (int c = 1; c <= 64; c++) begin
      tick();
      check("cnt", cnt, 128'(c % 32));
      check("feedback", feedback, ((c % 32) != 0));
      if (c % 32 == 0) check("issue_nonce", core_nonce, nonce_vec(32'(4 * (c / 32))));
      if (c == 32) check("ex_not_yet", exhausted_ex, 0);
      if (c == 33) begin
        check("ex_exhausted", exhausted_ex, 1);
        check("ex_wrap_base", core_nonce_ex[31:0], 32'd0);
      end
    end

    // Single hit, core 2, base 0x100 -> 0xEE
    hit_at(64, 4'b0100, 1'b1);
    check("lat_edge_n", gn_valid, 0);
    tick();
    check("lat_edge_n1", gn_valid, 1);
    check("single_data", gn_data, 32'hEE);
    check("single_level", fifo_level, 1);
    gn_ready = 1'b1;
    wait_drain("single_drain");
    check("single_empty", fifo_level, 0);

    // Two hits same sample, base 0x200 -> 0x1EC then 0x1EF
    hit_at(128, 4'b1001, 1'b1);
    tick();
    check("dual_first", gn_data, 32'h1EC);
    tick();
    check("dual_second", gn_data, 32'h1EF);
    tick();
    check("dual_empty", gn_valid, 0);

    // Overflow: 9 hits with gn_ready low; the 9th is dropped
    gn_ready = 1'b0;
    for (int j = 0; j < 9; j++) hit_at(129 + j, 4'(1 << (j % 4)), (j < 8));
    tick();
    tick();
    check("ovf_level", fifo_level, 8);
    check("ovf_drop", drop_count, 1);
    check("ovf_head", gn_data, 32'h1F0);
    gn_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_empty_level", fifo_level, 0);
    check("ovf_empty_vld", gn_valid, 0);

    // Restart mid-drain
    gn_ready = 1'b0;
    hit_at(138, 4'b1111, 1'b1);
    tick();
    tick();
    check("nw_pre_level", fifo_level, 2);
    new_work = 1'b1;
    tick();
    new_work = 1'b0;
    exp_q.delete();
    work_cyc0 = cyc;
    check("nw_level", fifo_level, 0);
    check("nw_vld", gn_valid, 0);
    check("nw_cnt", cnt, 0);
    check("nw_base", core_nonce, nonce_vec(32'd0));
    check("nw_drop_kept", drop_count, 1);
    gn_ready = 1'b1;
    for (int k = 1; k <= 5; k++) hit_at(k, 4'b0010, 1'b0);
    tick();
    tick();
    check("flush_level", fifo_level, 0);
    check("flush_vld", gn_valid, 0);
    gn_ready = 1'b0;
    hit_at(6, 4'b0010, 1'b1);
    tick();
    check("post_flush_vld", gn_valid, 1);
    check("post_flush_data", gn_data, 32'd5);
    gn_ready = 1'b1;
    wait_drain("post_flush_drain");

    // Exhaustion clear on dut_ex
    check("ex_sticky", exhausted_ex, 1);
    new_work_ex = 1'b1;
    tick();
    new_work_ex = 1'b0;
    check("ex_cleared", exhausted_ex, 0);
    check("ex_restart_base", core_nonce_ex[31:0], 32'hFFFF_FFF8);
    check("ex_restart_cnt", cnt_ex, 0);
    check("ex_restart_fb", feedback_ex, 0);
    check("ex_no_gn", {gn_valid_ex, fifo_level_ex, drop_count_ex, gn_data_ex}, 0);

    check("final_drop", drop_count, 1);
    check("final_queue", 128'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
